// File: rtl/add_seq.sv
// Initiator-side sequencer for the vector add exec unit: reads two operand
// words, runs one start/done handshake with a bounded wait, writes the result.
module add_seq #(
  parameter int N       = 176,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr_a,
  input  logic [ADDR_W-1:0]   cmd_addr_b,
  input  logic [ADDR_W-1:0]   cmd_addr_c,
  input  logic [15:0]         cmd_s_a,
  input  logic [15:0]         cmd_s_b,
  input  logic [7:0]          cmd_z_tot,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [N*8-1:0]      rd_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [N*8-1:0]      wr_data,
  output logic [N*8-1:0]      eu_a,
  output logic [N*8-1:0]      eu_b,
  output logic [15:0]         eu_s_a,
  output logic [15:0]         eu_s_b,
  output logic [7:0]          eu_z_tot,
  output logic                eu_start,
  input  logic [N*8-1:0]      eu_c,
  input  logic                eu_done,
  output logic                done,
  output logic                err
);

  localparam int W     = N * 8;
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_START, S_WAIT, S_WRITE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
  logic [ADDR_W-1:0]   addr_c_q, addr_c_d;
  logic [15:0]         s_a_q, s_a_d;
  logic [15:0]         s_b_q, s_b_d;
  logic [7:0]          z_q, z_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [W-1:0]        c_q, c_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_hit;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_a_q <= '0;
      addr_b_q <= '0;
      addr_c_q <= '0;
      s_a_q    <= '0;
      s_b_q    <= '0;
      z_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      addr_c_q <= addr_c_d;
      s_a_q    <= s_a_d;
      s_b_q    <= s_b_d;
      z_q      <= z_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
    end
  end

  // Completion wins over timeout when both land in the same WAIT cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_RD_A;
      S_RD_A:  state_d = S_RD_B;
      S_RD_B:  state_d = S_CAP_B;
      S_CAP_B: state_d = S_START;
      S_START: state_d = eu_done ? S_WRITE : S_WAIT;
      S_WAIT: begin
        if (eu_done)          state_d = S_WRITE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    addr_c_d = addr_c_q;
    s_a_d    = s_a_q;
    s_b_d    = s_b_q;
    z_d      = z_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_a_d = cmd_addr_a;
          addr_b_d = cmd_addr_b;
          addr_c_d = cmd_addr_c;
          s_a_d    = cmd_s_a;
          s_b_d    = cmd_s_b;
          z_d      = cmd_z_tot;
        end
      end
      S_RD_B:  a_d = rd_data;
      S_CAP_B: b_d = rd_data;
      S_START: begin
        cnt_d = '0;
        if (eu_done) c_d = eu_c;
      end
      S_WAIT: begin
        if (eu_done)           c_d   = eu_c;
        else if (!timeout_hit) cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    rd_en     = (state_q == S_RD_A) || (state_q == S_RD_B);
    rd_addr   = (state_q == S_RD_B) ? addr_b_q : addr_a_q;
    eu_start  = (state_q == S_START);
    wr_en     = (state_q == S_WRITE);
    done      = (state_q == S_WRITE);
    err       = (state_q == S_WAIT) && timeout_hit && !eu_done;
  end

  assign wr_addr  = addr_c_q;
  assign wr_data  = c_q;
  assign eu_a     = a_q;
  assign eu_b     = b_q;
  assign eu_s_a   = s_a_q;
  assign eu_s_b   = s_b_q;
  assign eu_z_tot = z_q;

endmodule

// File: doc/add_seq.md
Name: add_seq

Overview:
- Command-driven sequencer that acts as the initiator side of the vector add exec unit's start/done handshake.
- Per command it performs the following, then returns to idle:
  - reads operand vectors a and b from the activation buffer (1-cycle-latency read port);
  - loads them and the scaling/zero fields into the exec unit and pulses start;
  - waits for done, or times out;
  - writes the result vector c back to the buffer.
- Sits between the NPU instruction decoder and the add exec unit.

Parameters:
- N, 176, vector lanes (8-bit each); buffer word width is N*8.
- ADDR_W, 8, activation buffer address width.
- TIMEOUT, 64, maximum cycles to wait for eu_done after eu_start; must be ≥ 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer idle, can accept a command
- cmd_addr_a  in  ADDR_W  operand a address
- cmd_addr_b  in  ADDR_W  operand b address
- cmd_addr_c  in  ADDR_W  result address
- cmd_s_a  in  16  scale for a
- cmd_s_b  in  16  scale for b
- cmd_z_tot  in  8 (signed)  total zero point
- rd_en  out  1  buffer read enable
- rd_addr  out  ADDR_W  buffer read address
- rd_data  in  N*8  read data, valid the cycle after rd_en
- wr_en  out  1  buffer write enable
- wr_addr  out  ADDR_W  buffer write address
- wr_data  out  N*8  buffer write data
- eu_a  out  N*8  operand a to exec unit
- eu_b  out  N*8  operand b to exec unit
- eu_s_a  out  16  scale a to exec unit
- eu_s_b  out  16  scale b to exec unit
- eu_z_tot  out  8  zero point to exec unit
- eu_start  out  1  one-cycle start pulse
- eu_c  in  N*8  exec unit result
- eu_done  in  1  exec unit completion
- done  out  1  one-cycle pulse, result written
- err  out  1  one-cycle pulse, exec unit timeout

Behaviour:

Clock and reset:
- Single clock clk; reset rst is synchronous, active-high.
- Reset from any state forces IDLE.
- All pulse/enable outputs go to 0 (rd_en, wr_en, eu_start, done, err); cmd_ready=1 while in IDLE.
- All data/address registers clear to 0.
- A command in flight is abandoned: no write, no done, no err.

Output decode:
- FSM outputs are Moore-decoded from the state.
- eu_a, eu_b, eu_s_a, eu_s_b, eu_z_tot and wr_data come directly from holding registers and stay stable from capture until the next command overwrites them.

States (one cycle each unless noted):
- IDLE: cmd_ready=1. When cmd_valid=1, latch all cmd_* fields → RD_A. The cmd_* inputs are ignored in every other state.
- RD_A: rd_en=1, rd_addr=addr_a → RD_B.
- RD_B: rd_en=1, rd_addr=addr_b; capture rd_data into a_reg → CAP_B.
- CAP_B: capture rd_data into b_reg → START.
- START: eu_start=1; load the wait counter with 0.
  - If eu_done=1 in this cycle, capture eu_c into c_reg → WRITE.
  - Otherwise → WAIT.
- WAIT: counter increments each cycle.
  - If eu_done=1, capture eu_c → WRITE.
  - Else, when counter reaches TIMEOUT-1, err=1 for that cycle → IDLE, with no write and no done.
  - eu_done has priority over timeout when both occur in the same cycle.
- WRITE: wr_en=1, wr_addr=addr_c, wr_data=c_reg, done=1 → IDLE.

Timing and boundary rules:
- Minimum latency is 6 cycles from the command-accept edge to cmd_ready high again (eu_done in START): RD_A, RD_B, CAP_B, START, WRITE, then IDLE.
- The earliest eu_done is sampled in START; eu_done outside START/WAIT is ignored.
- Aliased addresses are legal:
  - addr_a = addr_b: the same word is read twice.
  - addr_c equal to either operand: overwriting happens only in WRITE, after both reads.
- Back-to-back commands are accepted on the IDLE cycle immediately after WRITE or after a timeout.
- No arithmetic in this block; lane data passes through unmodified.

Test Plan:
- Reset, then one command: a@0x10 = all lanes 0x05, b@0x20 = all 0x03, c→0x30; exec model returns done in START with c = 0x08 per lane → wr_en in cycle 5 after accept, wr_addr=0x30, wr_data all 0x08, done pulse same cycle, cmd_ready high next cycle.
- Exec model delays done by 10 cycles after start → eu_start high exactly 1 cycle; wr_en 1 cycle after the done sample; eu_a, eu_b, eu_s_a=0x1234, eu_s_b=0x0042, eu_z_tot=-3 held stable throughout the wait.
- Exec model never asserts done, TIMEOUT=64 → err pulses 64 cycles after START; no wr_en; cmd_ready returns high.
- Two back-to-back commands, second with addr_c=addr_a=0x10 → both reads of the second command are issued before its write; results land at the correct addresses; cmd_valid held high during busy does not cause a double accept.
- rst asserted during WAIT → next cycle: IDLE, cmd_ready=1, eu_start/wr_en/done/err=0; a late eu_done is ignored; a fresh command completes normally.
- eu_done coinciding with the TIMEOUT-1 count → WRITE taken, done pulses, err stays 0.
